// File: rtl/w_stream_tx.sv
// w_stream_tx
//   Serial transmitter for the single-bit w line read by the link-partner
//   pattern detector. It accepts WIDTH-bit frames on a valid/ready handshake
//   and shifts each one out MSB-first, then drives GAP idle zeros. A
//   cycle-exact model of the detector runs in parallel. It produces z_pred
//   and a per-frame hit flag.
//
// Ports
//   clk         rising-edge clock
//   reset_n     synchronous, active-low reset
//   in_valid    a frame is offered
//   in_ready    a frame is accepted on an edge where in_valid && in_ready
//   in_data     frame bits; bit WIDTH-1 is sent first
//   w           registered serial line to the detector
//   busy        transmitter is not idle
//   z_pred      detector z model (tracker in E or F)
//   frame_done  1-cycle pulse in the first idle cycle after a completed frame
//   frame_hit   z_pred was seen high during the frame; held until the next accept
module w_stream_tx #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned GAP   = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             w,
  output logic             busy,
  output logic             z_pred,
  output logic             frame_done,
  output logic             frame_hit
);

  // One counter serves both the bit phase and the gap phase.
  localparam int unsigned CNT_W = $clog2(WIDTH + GAP + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'((GAP > 0) ? (GAP - 1) : 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_GAP
  } tx_state_t;

  typedef enum logic [2:0] {
    TRK_A,
    TRK_B,
    TRK_C,
    TRK_D,
    TRK_E,
    TRK_F
  } trk_t;

  tx_state_t        state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [WIDTH-1:0] shreg, shreg_next;
  logic             w_next;
  logic             done_next;
  logic             clear_hit;
  trk_t             trk, trk_next;
  logic             z_next;

  assign in_ready = (state == ST_IDLE) && reset_n;
  assign busy     = (state != ST_IDLE);
  assign z_pred   = (trk == TRK_E) || (trk == TRK_F);

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    shreg_next = shreg;
    w_next     = 1'b0;
    done_next  = 1'b0;
    clear_hit  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          state_next = ST_SHIFT;
          w_next     = in_data[WIDTH-1];
          shreg_next = in_data << 1;
          cnt_next   = LAST_BIT;
          clear_hit  = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (cnt == '0) begin
          if (GAP == 0) begin
            state_next = ST_IDLE;
            done_next  = 1'b1;
          end else begin
            state_next = ST_GAP;
            cnt_next   = GAP_LOAD;
          end
        end else begin
          w_next     = shreg[WIDTH-1];
          shreg_next = shreg << 1;
          cnt_next   = cnt - 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt == '0) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Detector model. It consumes the registered w, so it lags w by one cycle,
  // exactly like the real detector.
  always_comb begin
    trk_next = TRK_A;
    case (trk)
      TRK_A:   trk_next = w ? TRK_B : TRK_A;
      TRK_B:   trk_next = w ? TRK_C : TRK_D;
      TRK_C:   trk_next = w ? TRK_E : TRK_D;
      TRK_D:   trk_next = w ? TRK_F : TRK_A;
      TRK_E:   trk_next = w ? TRK_E : TRK_D;
      TRK_F:   trk_next = w ? TRK_C : TRK_D;
      default: trk_next = TRK_A;
    endcase
    z_next = (trk_next == TRK_E) || (trk_next == TRK_F);
  end

  // The sticky hit register samples the z value that becomes visible in the
  // following cycle. This lets the frame_done cycle's own z_pred be included.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      shreg      <= '0;
      w          <= 1'b0;
      frame_done <= 1'b0;
      frame_hit  <= 1'b0;
      trk        <= TRK_A;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      shreg      <= shreg_next;
      w          <= w_next;
      frame_done <= done_next;
      trk        <= trk_next;
      if (clear_hit) begin
        frame_hit <= 1'b0;
      end else if (state != ST_IDLE) begin
        frame_hit <= frame_hit | z_next;
      end
    end
  end

endmodule

// File: tb/tb_w_stream_tx.sv
// tb_w_stream_tx
//   Self-checking bench for w_stream_tx with WIDTH=8 and GAP=2. A per-cycle
//   expectation record is queued for each accepted frame. Each record is
//   popped and compared against the DUT in the matching cycle.
module tb_w_stream_tx;

  localparam int unsigned W = 8;
  localparam int unsigned G = 2;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         w;
  logic         busy;
  logic         z_pred;
  logic         frame_done;
  logic         frame_hit;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic w;
    logic z;
    logic busy;
    logic rdy;
    logic done;
    logic hit;
  } exp_t;

  exp_t sb[$];

  w_stream_tx #(.WIDTH(W), .GAP(G)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .w          (w),
    .busy       (busy),
    .z_pred     (z_pred),
    .frame_done (frame_done),
    .frame_hit  (frame_hit)
  );

  always #5 clk = ~clk;

  // Detector reference, with states A..F encoded as 0..5.
  function automatic int trk_step(input int s, input logic b);
    case (s)
      0:       return b ? 1 : 0;
      1:       return b ? 2 : 3;
      2:       return b ? 4 : 3;
      3:       return b ? 5 : 0;
      4:       return b ? 4 : 3;
      5:       return b ? 2 : 3;
      default: return 0;
    endcase
  endfunction

  // Queue the expectations for cycles j=0..W+G after the accept edge. The
  // tracker is in A at j=0 because the previous gap (or idle time) flushed it.
  task automatic push_frame(input logic [W-1:0] d);
    exp_t e;
    int   s = 0;
    logic hit = 1'b0;
    logic prev_w = 1'b0;
    for (int j = 0; j <= int'(W + G); j++) begin
      e.w = (j < int'(W)) ? d[W-1-j] : 1'b0;
      if (j > 0) s = trk_step(s, prev_w);
      e.z = (s >= 4);
      if (j > 0) hit = hit | e.z;
      e.busy = (j < int'(W + G));
      e.rdy  = (j == int'(W + G));
      e.done = (j == int'(W + G));
      e.hit  = hit;
      prev_w = e.w;
      sb.push_back(e);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      vectors++;
      if ({w, in_ready, z_pred, busy, frame_done, frame_hit} !== 6'b0) begin
        miscompares++;
        $display("FAIL reset_hold c=%0d got w/rdy/z/busy/done/hit=%b want 000000", c,
                 {w, in_ready, z_pred, busy, frame_done, frame_hit});
      end
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({in_ready, busy, w} !== 3'b100) begin
      miscompares++;
      $display("FAIL reset_release got rdy/busy/w=%b want 100", {in_ready, busy, w});
    end
  endtask

  task automatic test_single_frames;
    logic [W-1:0] pat[6];
    int           zc_want[6];
    int           zc;
    int           n;
    exp_t         e;
    pat = '{8'hE0, 8'h80, 8'hA0, 8'h00, 8'h00, 8'h00};
    zc_want = '{1, 0, 1, -1, -1, -1};
    for (int i = 3; i < 6; i++) pat[i] = W'($urandom);
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (in_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL single_ready f=%0d got %b want 1", i, in_ready);
      end
      in_valid = 1'b1;
      in_data  = pat[i];
      push_frame(pat[i]);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = W'($urandom);
      zc = 0;
      n  = 0;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        vectors++;
        if ({w, z_pred, busy, in_ready, frame_done} !== {e.w, e.z, e.busy, e.rdy, e.done}) begin
          miscompares++;
          $display("FAIL single_cycle d=%h j=%0d got w/z/busy/rdy/done=%b want %b", pat[i], n,
                   {w, z_pred, busy, in_ready, frame_done}, {e.w, e.z, e.busy, e.rdy, e.done});
        end
        if (e.done) begin
          vectors++;
          if (frame_hit !== e.hit) begin
            miscompares++;
            $display("FAIL single_hit d=%h got %b want %b", pat[i], frame_hit, e.hit);
          end
        end
        zc += int'(z_pred);
        n++;
        if (sb.size() > 0) begin
          @(posedge clk); #1;
        end
      end
      if (zc_want[i] >= 0) begin
        vectors++;
        if (zc !== zc_want[i]) begin
          miscompares++;
          $display("FAIL single_zcount d=%h got %0d want %0d", pat[i], zc, zc_want[i]);
        end
      end
      e.hit = frame_hit;
      @(posedge clk); #1;
      vectors++;
      if ({frame_done, frame_hit} !== {1'b0, e.hit}) begin
        miscompares++;
        $display("FAIL single_after d=%h got done/hit=%b want 0%b", pat[i],
                 {frame_done, frame_hit}, e.hit);
      end
    end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int   n = 0;
    int   zc = 0;
    int   dones = 0;
    in_valid = 1'b1;
    in_data  = 8'hFF;
    push_frame(8'hFF);
    push_frame(8'h00);
    @(posedge clk); #1;
    in_data = 8'h00;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (n == int'(W + G + 1)) in_valid = 1'b0;
      vectors++;
      if ({w, z_pred, busy, in_ready, frame_done} !== {e.w, e.z, e.busy, e.rdy, e.done}) begin
        miscompares++;
        $display("FAIL b2b_cycle n=%0d got w/z/busy/rdy/done=%b want %b", n,
                 {w, z_pred, busy, in_ready, frame_done}, {e.w, e.z, e.busy, e.rdy, e.done});
      end
      if (e.done) begin
        vectors++;
        if (frame_hit !== e.hit) begin
          miscompares++;
          $display("FAIL b2b_hit n=%0d got %b want %b", n, frame_hit, e.hit);
        end
      end
      zc += int'(z_pred);
      dones += int'(frame_done);
      n++;
      if (sb.size() > 0) begin
        @(posedge clk); #1;
      end
    end
    vectors++;
    if (zc !== 6 || dones !== 2) begin
      miscompares++;
      $display("FAIL b2b_counts got z=%0d done=%0d want z=6 done=2", zc, dones);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort;
    exp_t e;
    int   dones = 0;
    in_valid = 1'b1;
    in_data  = 8'hFF;
    push_frame(8'hFF);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int n = 0; n < 4; n++) begin
      e = sb.pop_front();
      vectors++;
      if ({w, z_pred, busy, in_ready} !== {e.w, e.z, e.busy, e.rdy}) begin
        miscompares++;
        $display("FAIL abort_pre j=%0d got w/z/busy/rdy=%b want %b", n,
                 {w, z_pred, busy, in_ready}, {e.w, e.z, e.busy, e.rdy});
      end
      if (n == 3) reset_n = 1'b0;
      @(posedge clk); #1;
    end
    sb.delete();
    vectors++;
    if ({w, z_pred, busy, frame_done, in_ready} !== 5'b0) begin
      miscompares++;
      $display("FAIL abort_reset got w/z/busy/done/rdy=%b want 00000",
               {w, z_pred, busy, frame_done, in_ready});
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_ready got %b want 1", in_ready);
    end
    for (int c = 0; c < 12; c++) begin
      dones += int'(frame_done);
      @(posedge clk); #1;
    end
    vectors++;
    if (dones !== 0) begin
      miscompares++;
      $display("FAIL abort_no_done got %0d pulses want 0", dones);
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    test_reset;
    test_single_frames;
    test_back_to_back;
    test_reset_abort;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
